// File: rtl/charli_pwm_scanner.sv
// charli_pwm_scanner
//   Charlieplexed LED scanner with per-LED PWM brightness. N_PINS tri-state pins drive
//   NLED = N_PINS*(N_PINS-1) LEDs, one LED slot at a time. Each slot is 2**BW PWM ticks
//   of TICK_DIV clocks. Tick 0 of each slot is blanked. The LED is driven on ticks
//   1..duty. New frames go into a shadow buffer through a valid/ready handshake and
//   become active only at the frame boundary, so a frame never tears.
//
// Optional feature (compile-time macro SKIP_DARK_EN):
//   When defined, a slot whose duty is 0 lasts a single clock instead of a full slot.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   frame_data   in   NLED*BW brightness values, LED k at [k*BW +: BW]
//   frame_valid  in   frame_data valid
//   frame_ready  out  shadow buffer empty; transfer on frame_valid & frame_ready
//   pin_o        out  pin drive level (0 whenever the pin is not enabled)
//   pin_oe       out  pin output enable (0 = high impedance)
//   frame_sync   out  one-clock pulse on the first output clock of each frame
module charli_pwm_scanner #(
    parameter int unsigned N_PINS   = 4,
    parameter int unsigned BW       = 4,
    parameter int unsigned TICK_DIV = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_PINS*(N_PINS-1)*BW-1:0]    frame_data,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic [N_PINS-1:0]                  pin_o,
    output logic [N_PINS-1:0]                  pin_oe,
    output logic                               frame_sync
);

    localparam int unsigned NLED = N_PINS * (N_PINS - 1);
    localparam int unsigned SW   = (NLED > 1) ? $clog2(NLED) : 1;
    localparam int unsigned DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FW   = NLED * BW;

    localparam logic [SW-1:0] LastSlot = SW'(NLED - 1);
    localparam logic [DW-1:0] LastDiv  = DW'(TICK_DIV - 1);
    localparam logic [BW-1:0] LastTick = '1;

    // LED k: anode is k/(N_PINS-1); cathode skips over the anode index.
    function automatic int unsigned anode_of(input int unsigned k);
        return k / (N_PINS - 1);
    endfunction

    function automatic int unsigned cathode_of(input int unsigned k);
        int unsigned c0;
        c0 = k % (N_PINS - 1);
        return (c0 >= anode_of(k)) ? c0 + 1 : c0;
    endfunction

    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     tick_q, tick_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [FW-1:0]     active_q, active_d;
    logic [FW-1:0]     shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              ready_q, ready_d;
    logic [N_PINS-1:0] pin_o_q, pin_o_d;
    logic [N_PINS-1:0] pin_oe_q, pin_oe_d;
    logic              sync_q, sync_d;

    logic [BW-1:0]     duty;
    logic [N_PINS-1:0] anode_mask;
    logic [N_PINS-1:0] cathode_mask;
    logic              slot_end;
    logic              frame_end;
    logic              lit;

    // Current slot decode: duty and pin masks.
    always_comb begin
        duty         = '0;
        anode_mask   = '0;
        cathode_mask = '0;
        for (int unsigned k = 0; k < NLED; k++) begin
            if (slot_q == SW'(k)) begin
                duty         = active_q[k*BW +: BW];
                anode_mask   = N_PINS'(1) << anode_of(k);
                cathode_mask = N_PINS'(1) << cathode_of(k);
            end
        end
    end

    always_comb begin
`ifdef SKIP_DARK_EN
        slot_end = (duty == '0) || ((tick_q == LastTick) && (div_q == LastDiv));
`else
        slot_end = (tick_q == LastTick) && (div_q == LastDiv);
`endif
        frame_end = slot_end && (slot_q == LastSlot);

        div_d  = div_q + 1'b1;
        tick_d = tick_q;
        slot_d = slot_q;
        if (slot_end) begin
            div_d  = '0;
            tick_d = '0;
            slot_d = (slot_q == LastSlot) ? '0 : slot_q + 1'b1;
        end else if (div_q == LastDiv) begin
            div_d  = '0;
            tick_d = tick_q + 1'b1;
        end

        // Tick 0 is the anti-ghosting blank; duty 0 is never lit.
        lit      = (tick_q != '0) && (tick_q <= duty);
        pin_oe_d = lit ? (anode_mask | cathode_mask) : '0;
        pin_o_d  = lit ? anode_mask : '0;
        sync_d   = (slot_q == '0) && (tick_q == '0) && (div_q == '0);

        // Swap and capture are mutually exclusive: capture needs an empty shadow.
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        if (frame_end && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (frame_valid && ready_q) begin
            shadow_d      = frame_data;
            shadow_full_d = 1'b1;
        end
        ready_d = !shadow_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q         <= '0;
            tick_q        <= '0;
            slot_q        <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            ready_q       <= 1'b0;
            pin_o_q       <= '0;
            pin_oe_q      <= '0;
            sync_q        <= 1'b0;
        end else begin
            div_q         <= div_d;
            tick_q        <= tick_d;
            slot_q        <= slot_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            ready_q       <= ready_d;
            pin_o_q       <= pin_o_d;
            pin_oe_q      <= pin_oe_d;
            sync_q        <= sync_d;
        end
    end

    assign frame_ready = ready_q;
    assign pin_o       = pin_o_q;
    assign pin_oe      = pin_oe_q;
    assign frame_sync  = sync_q;

endmodule

// File: tb/tb_charli_pwm_scanner.sv
module tb_charli_pwm_scanner;

    localparam int unsigned N_PINS   = 4;
    localparam int unsigned BW       = 4;
    localparam int unsigned TICK_DIV = 2;
    localparam int NLED     = N_PINS * (N_PINS - 1);
    localparam int SLOT_LEN = TICK_DIV * (1 << BW);
    localparam int DMAX     = (1 << BW) - 1;

    localparam int unsigned N5    = 5;
    localparam int unsigned BW5   = 1;
    localparam int          NLED5 = 20;

`ifdef SKIP_DARK_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NLED*BW-1:0]     frame_data;
    logic                   frame_valid;
    logic                   frame_ready;
    logic [N_PINS-1:0]      pin_o;
    logic [N_PINS-1:0]      pin_oe;
    logic                   frame_sync;

    logic [NLED5*BW5-1:0]   data5;
    logic                   valid5;
    logic                   ready5;
    logic [N5-1:0]          pin_o5;
    logic [N5-1:0]          pin_oe5;
    logic                   sync5;

    charli_pwm_scanner #(
        .N_PINS   (N_PINS),
        .BW       (BW),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pin_o       (pin_o),
        .pin_oe      (pin_oe),
        .frame_sync  (frame_sync)
    );

    charli_pwm_scanner #(
        .N_PINS   (N5),
        .BW       (BW5),
        .TICK_DIV (1)
    ) dut5 (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (data5),
        .frame_valid (valid5),
        .frame_ready (ready5),
        .pin_o       (pin_o5),
        .pin_oe      (pin_oe5),
        .frame_sync  (sync5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: frame-time based. mt is the clock index within the current frame.
    int          m_active[NLED];
    int          m_shadow[NLED];
    bit          m_full;
    int          mt, ms, moff, mflen, mtick, ma, mc;
    bit          m_cap;
    logic        exp_ready, exp_sync;
    logic [N_PINS-1:0] exp_oe, exp_o;

    function automatic int slot_len(input int d);
        return (SKIP && d == 0) ? 1 : SLOT_LEN;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mt = 0;
            m_full = 1'b0;
            foreach (m_active[k]) m_active[k] = 0;
            exp_ready = 1'b0;
            exp_sync  = 1'b0;
            exp_oe    = '0;
            exp_o     = '0;
        end else begin
            mflen = 0;
            foreach (m_active[k]) mflen += slot_len(m_active[k]);
            ms = 0;
            moff = mt;
            while (ms < NLED - 1 && moff >= slot_len(m_active[ms])) begin
                moff -= slot_len(m_active[ms]);
                ms++;
            end
            mtick = moff / TICK_DIV;
            exp_sync = (mt == 0);
            exp_oe = '0;
            exp_o  = '0;
            if (mtick >= 1 && mtick <= m_active[ms]) begin
                ma = ms / (N_PINS - 1);
                mc = ms % (N_PINS - 1);
                if (mc >= ma) mc++;
                exp_oe = N_PINS'(1 << ma) | N_PINS'(1 << mc);
                exp_o  = N_PINS'(1 << ma);
            end
            m_cap = frame_valid && exp_ready;
            if (mt == mflen - 1) begin
                mt = 0;
                if (m_full) begin
                    m_active = m_shadow;
                    m_full = 1'b0;
                end
            end else begin
                mt++;
            end
            if (m_cap) begin
                for (int k = 0; k < NLED; k++) m_shadow[k] = int'(frame_data[k*BW +: BW]);
                m_full = 1'b1;
            end
            exp_ready = !m_full;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("ready", 32'(frame_ready), 32'(exp_ready));
            check_eq("sync", 32'(frame_sync), 32'(exp_sync));
            check_eq("pin_oe", 32'(pin_oe), 32'(exp_oe));
            check_eq("pin_o", 32'(pin_o), 32'(exp_o));
        end
    end

    task automatic wait_sync(output int when);
        when = -1;
        @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            if (frame_sync) begin
                when = cyc;
                return;
            end
            @(negedge clk);
        end
        check_eq("sync_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [NLED*BW-1:0] d);
        bit done;
        done = 1'b0;
        frame_data  = d;
        frame_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (frame_ready) done = 1'b1;
            @(negedge clk);
        end
        frame_valid = 1'b0;
        if (!done) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [NLED*BW-1:0] rand_frame();
        logic [NLED*BW-1:0] f;
        int r;
        for (int k = 0; k < NLED; k++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      f[k*BW +: BW] = '0;
            else if (r == 1) f[k*BW +: BW] = BW'(DMAX);
            else             f[k*BW +: BW] = BW'($urandom_range(0, DMAX));
        end
        return f;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1, t2, cnt, s5, a5, c5;
        logic [NLED*BW-1:0] f;
        rst = 1'b0;
        frame_valid = 1'b0;
        frame_data = '0;
        valid5 = 1'b0;
        data5 = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_eq("rst_ready", 32'(frame_ready), 32'd0);
        check_eq("rst_oe", 32'(pin_oe), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // All-zero frame period straight after reset.
        wait_sync(t1);
        check_eq("first_sync_cycle", 32'(t1 - cyc), 32'd0);
        wait_sync(t2);
        check_eq("dark_period", 32'(t2 - t1), SKIP ? 32'(NLED) : 32'(NLED * SLOT_LEN));

        // Only LED5 at full brightness: anode 1, cathode 3.
        f = '0;
        f[5*BW +: BW] = BW'(DMAX);
        send_frame(f);
        wait_sync(t1);
        wait_sync(t1);
        cnt = 0;
        for (int i = 0; i < (SKIP ? (NLED - 1 + SLOT_LEN) : NLED * SLOT_LEN); i++) begin
            if (pin_oe == 4'b1010 && pin_o == 4'b0010) cnt++;
            @(negedge clk);
        end
        check_eq("led5_lit_clks", 32'(cnt), 32'd30);
        check_eq("led5_period", 32'(frame_sync), 32'd1);

        // LED0 at duty 3: 3 ticks lit.
        f = '0;
        f[0 +: BW] = BW'(3);
        send_frame(f);
        wait_sync(t1);
        wait_sync(t1);
        cnt = 0;
        for (int i = 0; i < SLOT_LEN; i++) begin
            if (pin_oe == 4'b0011) cnt++;
            @(negedge clk);
        end
        check_eq("led0_lit_clks", 32'(cnt), 32'd6);

        // Random frames with random gaps.
        for (int it = 0; it < 6; it++) begin
            send_frame(rand_frame());
            repeat ($urandom_range(0, 400)) @(negedge clk);
        end

        // Back-to-back frames with valid held: second waits for the swap.
        send_frame(rand_frame());
        check_eq("ready_low_full", 32'(frame_ready), 32'd0);
        send_frame(rand_frame());
        repeat (500) @(negedge clk);

        // Reset mid-scan for 5 clocks.
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("midrst_oe", 32'(pin_oe), 32'd0);
        check_eq("midrst_ready", 32'(frame_ready), 32'd0);
        check_eq("midrst_sync", 32'(frame_sync), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", 32'(frame_ready), 32'd1);
        check_eq("rel_sync", 32'(frame_sync), 32'd1);
        send_frame(rand_frame());
        repeat (900) @(negedge clk);

        // Five-pin sweep: every LED at full duty, check mapping slot by slot.
        data5 = '1;
        valid5 = 1'b1;
        cnt = 0;
        while (!ready5 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        valid5 = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            cnt = 0;
            while (!sync5 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            if (!sync5) check_eq("sync5_timeout", 32'd0, 32'd1);
        end
        for (int j = 0; j < NLED5 * 2; j++) begin
            s5 = j / 2;
            a5 = s5 / (int'(N5) - 1);
            c5 = s5 % (int'(N5) - 1);
            if (c5 >= a5) c5++;
            if (j % 2 == 1) begin
                check_eq("n5_oe", 32'(pin_oe5), 32'((1 << a5) | (1 << c5)));
                check_eq("n5_o", 32'(pin_o5), 32'(1 << a5));
                check_eq("n5_pair", 32'($countones(pin_oe5)), 32'd2);
            end else begin
                check_eq("n5_blank", 32'(pin_oe5), 32'd0);
            end
            @(negedge clk);
        end
        check_eq("n5_period", 32'(sync5), 32'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
